// File: rtl/xtea_encipher.sv
// Iterative XTEA block encryptor: one Feistel half-round per clock,
// start/busy/done handshake, ROUNDS full cycles per 64-bit block.
module xtea_encipher #(
   parameter int unsigned  ROUNDS = 32,
   parameter logic [31:0]  DELTA  = 32'h9E3779B9
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [31:0]   data_in1,
   input  logic [31:0]   data_in2,
   input  logic [127:0]  key_in,
   output logic          busy,
   output logic          done,
   output logic [31:0]   data_out1,
   output logic [31:0]   data_out2
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RND_A = 2'd1;
   localparam logic [1:0] S_RND_B = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   localparam logic [8:0] ROUNDS_W = 9'(ROUNDS);

   logic [1:0]   state_q, state_d;
   logic [31:0]  v0_q, v0_d;
   logic [31:0]  v1_q, v1_d;
   logic [31:0]  sum_q, sum_d;
   logic [127:0] key_q, key_d;
   logic [7:0]   count_q, count_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [31:0]  out1_q, out1_d;
   logic [31:0]  out2_q, out2_d;

   logic [31:0]  key_a;
   logic [31:0]  key_b;
   logic [8:0]   count_inc;

   function automatic logic [31:0] mix(input logic [31:0] v);
      return ((v << 4) ^ (v >> 5)) + v;
   endfunction

   // k[0] sits in the top word, so word index i maps to bit offset (3-i)*32.
   assign key_a     = key_q[{~sum_q[1:0], 5'd0} +: 32];
   assign key_b     = key_q[{~sum_q[12:11], 5'd0} +: 32];
   assign count_inc = {1'b0, count_q} + 9'd1;

   always_comb begin
      state_d = state_q;
      v0_d    = v0_q;
      v1_d    = v1_q;
      sum_d   = sum_q;
      key_d   = key_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out1_d  = out1_q;
      out2_d  = out2_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               v0_d    = data_in1;
               v1_d    = data_in2;
               key_d   = key_in;
               sum_d   = 32'd0;
               count_d = 8'd0;
               busy_d  = 1'b1;
               state_d = S_RND_A;
            end
         end
         S_RND_A: begin
            v0_d    = v0_q + (mix(v1_q) ^ (sum_q + key_a));
            sum_d   = sum_q + DELTA;
            state_d = S_RND_B;
         end
         S_RND_B: begin
            // v0_q and sum_q already hold the values written in RND_A.
            v1_d    = v1_q + (mix(v0_q) ^ (sum_q + key_b));
            count_d = count_inc[7:0];
            state_d = (count_inc == ROUNDS_W) ? S_OUT : S_RND_A;
         end
         S_OUT: begin
            out1_d  = v0_q;
            out2_d  = v1_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         v0_q    <= 32'd0;
         v1_q    <= 32'd0;
         sum_q   <= 32'd0;
         key_q   <= 128'd0;
         count_q <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out1_q  <= 32'd0;
         out2_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         sum_q   <= sum_d;
         key_q   <= key_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out1_q  <= out1_d;
         out2_q  <= out2_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign data_out1 = out1_q;
   assign data_out2 = out2_q;

endmodule

// File: tb/tb_xtea_encipher.sv
// Randomized scoreboard bench for xtea_encipher against a loop-level XTEA
// model; a second instance covers the single-round build.
module tb_xtea_encipher;

   localparam logic [31:0] DELTA = 32'h9E3779B9;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   data_in1 = '0, data_in2 = '0;
   logic [127:0]  key_in = '0;
   logic          busy, done;
   logic [31:0]   data_out1, data_out2;

   logic          start1 = 1'b0;
   logic [31:0]   d1_in1 = '0, d1_in2 = '0;
   logic [127:0]  key1_in = '0;
   logic          busy1, done1;
   logic [31:0]   d1_out1, d1_out2;

   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;
   int            exp_dones = 0;
   logic [63:0]   exp_q[$];
   logic          prev_done = 1'b0;

   always #5 clock = ~clock;

   xtea_encipher #(.ROUNDS(32), .DELTA(DELTA)) dut (
      .clock(clock), .reset(reset), .start(start),
      .data_in1(data_in1), .data_in2(data_in2), .key_in(key_in),
      .busy(busy), .done(done), .data_out1(data_out1), .data_out2(data_out2)
   );

   xtea_encipher #(.ROUNDS(1), .DELTA(DELTA)) dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .data_in1(d1_in1), .data_in2(d1_in2), .key_in(key1_in),
      .busy(busy1), .done(done1), .data_out1(d1_out1), .data_out2(d1_out2)
   );

   function automatic logic [31:0] kw(input logic [127:0] key, input int idx);
      logic [31:0] w [4];
      w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
      return w[idx];
   endfunction

   function automatic logic [31:0] f(input logic [31:0] v);
      return ((v << 4) ^ (v >> 5)) + v;
   endfunction

   function automatic logic [63:0] enc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [127:0] key, input int rounds);
      logic [31:0] s = 32'd0;
      for (int i = 0; i < rounds; i++) begin
         a += f(b) ^ (s + kw(key, int'(s & 32'd3)));
         s += DELTA;
         b += f(a) ^ (s + kw(key, int'((s >> 11) & 32'd3)));
      end
      return {a, b};
   endfunction

   function automatic logic [63:0] dec(input logic [31:0] a, input logic [31:0] b,
                                       input logic [127:0] key, input int rounds);
      logic [31:0] s = DELTA * 32'(rounds);
      for (int i = 0; i < rounds; i++) begin
         b -= f(a) ^ (s + kw(key, int'((s >> 11) & 32'd3)));
         s -= DELTA;
         a -= f(b) ^ (s + kw(key, int'(s & 32'd3)));
      end
      return {a, b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every done pulse pops one expected ciphertext.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clock);
         if (!reset && done) begin
            done_cnt++;
            check("done_single_cycle", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: actual %h%h required no done", data_out1, data_out2);
            end else begin
               e = exp_q.pop_front();
               check("ciphertext", {data_out1, data_out2}, e);
            end
         end
         prev_done = done && !reset;
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [127:0] key);
      @(posedge clock); #1;
      data_in1 = a; data_in2 = b; key_in = key; start = 1'b1;
      exp_q.push_back(enc(a, b, key, 32));
      exp_dones++;
      @(posedge clock); #1;
      start = 1'b0;
      $display("issue v0=%h v1=%h key=%h", a, b, key);
   endtask

   // Called just after the accepting edge; lat counts edges until done is seen.
   task automatic wait_done(output int lat, input int budget);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         @(posedge clock); #2;
         if (done) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) check("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, lat2, busy_gap, dones_seen;
      logic [31:0] a, b;
      logic [127:0] key;
      logic [63:0] rt;
      localparam logic [127:0] KV = 128'h000102030405060708090a0b0c0d0e0f;

      repeat (3) @(posedge clock);
      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_out", {data_out1, data_out2}, 64'd0);
      reset = 1'b0;

      // Published test vector and latency.
      issue(32'h41424344, 32'h45464748, KV);
      wait_done(lat, 200);
      check("latency", 64'(lat), 64'd65);
      check("known_vector", {data_out1, data_out2}, 64'h497df3d0_72612cb5);

      // Random blocks, each also decrypted back by the model.
      for (int i = 0; i < 300; i++) begin
         a = $urandom; b = $urandom;
         key = {$urandom, $urandom, $urandom, $urandom};
         issue(a, b, key);
         wait_done(lat, 200);
         rt = dec(data_out1, data_out2, key, 32);
         check("round_trip", rt, {a, b});
         $display("block %0d ct=%h%h", i, data_out1, data_out2);
      end

      // start pulses mid-block must be ignored.
      issue(32'h41424344, 32'h45464748, KV);
      busy_gap = 0; dones_seen = 0;
      for (int k = 1; k <= 150; k++) begin
         @(posedge clock); #2;
         if (k == 10 || k == 40) begin
            data_in1 = $urandom; data_in2 = $urandom; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            dones_seen++;
            check("busy_low_at_done", {63'd0, busy}, 64'd0);
         end else if (dones_seen == 0 && !busy) begin
            busy_gap++;
         end
      end
      check("handshake_dones", 64'(dones_seen), 64'd1);
      check("busy_continuous", 64'(busy_gap), 64'd0);

      // Back-to-back with start held high.
      @(posedge clock); #1;
      data_in1 = 32'h41424344; data_in2 = 32'h45464748; key_in = KV; start = 1'b1;
      exp_q.push_back(64'h497df3d0_72612cb5);
      exp_dones++;
      @(posedge clock); #1;
      a = $urandom; b = $urandom;
      data_in1 = a; data_in2 = b;
      exp_q.push_back(enc(a, b, KV, 32));
      exp_dones++;
      wait_done(lat, 200);
      check("b2b_first", {data_out1, data_out2}, 64'h497df3d0_72612cb5);
      @(posedge clock); #1;
      start = 1'b0;
      wait_done(lat2, 200);
      check("b2b_second_latency", 64'(lat2), 64'd65);
      check("b2b_second", {data_out1, data_out2}, enc(a, b, KV, 32));
      $display("back_to_back ct=%h%h", data_out1, data_out2);

      // Reset in the middle of a block.
      issue($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
      repeat (29) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_busy", {63'd0, busy}, 64'd0);
      check("midreset_done", {63'd0, done}, 64'd0);
      check("midreset_out", {data_out1, data_out2}, 64'd0);
      exp_q.delete();
      exp_dones--;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (100) @(posedge clock);
      issue(32'h41424344, 32'h45464748, KV);
      wait_done(lat, 200);
      check("after_reset_latency", 64'(lat), 64'd65);

      // Single-round build.
      for (int t = 0; t < 2; t++) begin
         @(posedge clock); #1;
         if (t == 0) begin
            d1_in1 = 32'd0; d1_in2 = 32'd0; key1_in = 128'd0;
         end else begin
            d1_in1 = $urandom; d1_in2 = $urandom;
            key1_in = {$urandom, $urandom, $urandom, $urandom};
         end
         start1 = 1'b1;
         @(posedge clock); #1;
         start1 = 1'b0;
         lat = -1;
         for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #2;
            if (done1) begin
               lat = k;
               break;
            end
         end
         check("r1_latency", 64'(lat), 64'd3);
         check("r1_result", {d1_out1, d1_out2}, enc(d1_in1, d1_in2, key1_in, 1));
         if (t == 0) check("r1_zero_v0", {32'd0, d1_out1}, 64'd0);
         $display("rounds1 ct=%h%h", d1_out1, d1_out2);
      end

      repeat (5) @(posedge clock);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      check("done_count", 64'(done_cnt), 64'(exp_dones));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
